// File: rtl/mul_result_stage.sv
// mul_result_stage: final carry-propagate add and MUL/MULH/MULW result select, 2-stage valid/ready pipe, optional output skid via MUL_RESULT_SKID_EN
module mul_result_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_sum,
  input  logic [127:0] in_carry,
  input  logic [1:0]   in_op,
  input  logic         in_word,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  result
);
  logic        a_v, a_c, a_w, a_load, b_v, b_load;
  logic [1:0]  a_op;
  logic [63:0] a_sh, a_ch, a_l, b_r, h, sel;
  assign h   = a_sh + a_ch + {63'd0, a_c};
  assign sel = a_op != 2'd0 ? h : a_w ? {{32{a_l[31]}}, a_l[31:0]} : a_l;
`ifdef MUL_RESULT_SKID_EN
  logic        s_v;
  logic [63:0] s_r;
  assign b_load    = !b_v || !s_v;
  assign out_valid = s_v || b_v;
  assign result    = s_v ? s_r : b_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_v <= 1'b0;
      s_r <= 64'd0;
    end else if (flush) begin
      s_v <= 1'b0;
    end else if (s_v) begin
      s_v <= !out_ready;
    end else begin
      s_v <= b_v && !out_ready;
      if (b_v && !out_ready) s_r <= b_r;
    end
`else
  assign b_load    = !b_v || out_ready;
  assign out_valid = b_v;
  assign result    = b_r;
`endif
  assign a_load   = !a_v || b_load;
  assign in_ready = flush || a_load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_v  <= 1'b0;
      a_c  <= 1'b0;
      a_w  <= 1'b0;
      a_op <= 2'd0;
      a_sh <= 64'd0;
      a_ch <= 64'd0;
      a_l  <= 64'd0;
    end else if (flush) begin
      a_v <= 1'b0;
    end else if (a_load) begin
      a_v <= in_valid;
      if (in_valid) begin
        a_sh       <= in_sum[127:64];
        a_ch       <= in_carry[127:64];
        a_op       <= in_op;
        a_w        <= in_word && in_op == 2'd0;
        {a_c, a_l} <= {1'b0, in_sum[63:0]} + {1'b0, in_carry[63:0]};
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      b_v <= 1'b0;
      b_r <= 64'd0;
    end else if (flush) begin
      b_v <= 1'b0;
    end else if (b_load) begin
      b_v <= a_v;
      if (a_v) b_r <= sel;
    end
endmodule

// File: tb/tb_mul_result_stage.sv
// tb_mul_result_stage: vector table, corner sequences and random scoreboard against a 128-bit arithmetic model
module tb_mul_result_stage;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, in_word = 1'b0;
  logic [127:0] in_sum = '0, in_carry = '0;
  logic [1:0]   in_op = 2'd0;
  logic         in_ready, out_valid;
  logic [63:0]  result;
`ifdef MUL_RESULT_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif
  typedef struct {
    logic [127:0] s;
    logic [127:0] c;
    logic [1:0]   op;
    logic         w;
    logic [63:0]  e;
  } vec_t;
  vec_t        vt[9];
  logic [63:0] exp_q[$];
  int          t_q[$];
  int          n_chk = 0, n_fail = 0, cyc = 0, acc_n, out_n;
  bit          lat_chk, acc, fired, prev_ov, prev_or, prev_f;
  logic [63:0] prev_res, held;
  mul_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_op(in_op), .in_word(in_word),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(logic [127:0] s, logic [127:0] c, logic [1:0] op, logic w);
    logic [127:0] p;
    p = s + c;
    if (op != 2'd0) return p[127:64];
    if (w) return {{32{p[31]}}, p[31:0]};
    return p[63:0];
  endfunction
  task automatic step(logic v, logic [127:0] s, logic [127:0] c, logic [1:0] op, logic w, logic f, logic r, logic [63:0] e);
    logic [63:0] e0;
    int t0;
    @(negedge clk);
    in_valid = v; in_sum = s; in_carry = c; in_op = op; in_word = w; flush = f; out_ready = r;
    #1;
    cyc++;
    acc   = v && in_ready && !f;
    fired = out_valid && r;
    if (f) chk("flush_in_ready", in_ready, 1);
    if (prev_ov && !prev_or && !prev_f) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, prev_res);
    end
    prev_ov = out_valid; prev_or = r; prev_f = f; prev_res = result;
    if (fired) begin
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e0 = exp_q.pop_front();
        t0 = t_q.pop_front();
        chk("result", result, e0);
        if (lat_chk) chk("latency", cyc - t0, 2);
      end
    end
    if (f) begin
      exp_q.delete();
      t_q.delete();
    end else if (acc) begin
      exp_q.push_back(e);
      t_q.push_back(cyc);
    end
  endtask
  task automatic idle(logic r);
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, r, '0);
  endtask
  task automatic vec(int i, logic r);
    step(1'b1, vt[i].s, vt[i].c, vt[i].op, vt[i].w, 1'b0, r, vt[i].e);
  endtask
  initial begin
    vt[0] = '{128'h5, 128'h3, 2'd0, 1'b0, 64'h8};
    vt[1] = '{128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 2'd1, 1'b0, 64'h1};
    vt[2] = '{128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 2'd0, 1'b0, 64'h0};
    vt[3] = '{128'h8000_0000, 128'h0, 2'd0, 1'b1, 64'hFFFF_FFFF_8000_0000};
    vt[4] = '{128'h1_7FFF_FFFF, 128'h0, 2'd0, 1'b1, 64'h7FFF_FFFF};
    vt[5] = '{{64'h1234, 64'h8000_0000}, 128'h0, 2'd2, 1'b1, 64'h1234};
    vt[6] = '{{128{1'b1}}, 128'h2, 2'd1, 1'b0, 64'h0};
    vt[7] = '{{128{1'b1}}, 128'h2, 2'd0, 1'b0, 64'h1};
    vt[8] = '{{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000}, {64'h1, 64'h1_0000_0000}, 2'd3, 1'b0, 64'h0123_4567_89AB_CDF1};
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    lat_chk = 1;
    for (int i = 0; i < 9; i++) begin
      vec(i, 1'b1);
      chk("table_accept", acc, 1);
    end
    repeat (3) idle(1'b1);
    chk("table_drained", exp_q.size(), 0);
    lat_chk = 0;
    acc_n = 0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      step(acc_n < 3, vt[acc_n % 3].s, vt[acc_n % 3].c, vt[acc_n % 3].op, vt[acc_n % 3].w, 1'b0, 1'b0, vt[acc_n % 3].e);
      if (acc) acc_n++;
    end
    chk("bp_accepted", acc_n, CAP);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", result, vt[0].e);
    out_n = 0;
    for (int i = 0; i < 3; i++) begin
      step(acc_n < 3, vt[acc_n % 3].s, vt[acc_n % 3].c, vt[acc_n % 3].op, vt[acc_n % 3].w, 1'b0, 1'b1, vt[acc_n % 3].e);
      if (acc) acc_n++;
      chk("bp_drain_valid", out_valid, 1);
    end
    repeat (3) idle(1'b1);
    chk("bp_all_accepted", acc_n, 3);
    chk("bp_drained", exp_q.size(), 0);
    vec(0, 1'b0);
    vec(1, 1'b0);
    step(1'b1, vt[2].s, vt[2].c, vt[2].op, vt[2].w, 1'b1, 1'b0, vt[2].e);
    idle(1'b1);
    chk("flush_out_valid", out_valid, 0);
    repeat (4) idle(1'b1);
    vec(3, 1'b1);
    repeat (3) idle(1'b1);
    chk("flush_recover", exp_q.size(), 0);
    vec(0, 1'b0);
    vec(1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_in_ready", in_ready, 1);
    exp_q.delete();
    t_q.delete();
    prev_ov = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    lat_chk = 1;
    vec(4, 1'b1);
    chk("post_rst_accept", acc, 1);
    repeat (3) idle(1'b1);
    chk("post_rst_drained", exp_q.size(), 0);
    lat_chk = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [127:0] s, c;
      logic [1:0] op;
      logic w;
      s  = {$urandom(), $urandom(), $urandom(), $urandom()};
      c  = ($urandom % 4 == 0) ? 128'h0 : {$urandom(), $urandom(), $urandom(), $urandom()};
      op = 2'($urandom % 4);
      w  = 1'($urandom % 2);
      step($urandom % 4 != 0, s, c, op, w, $urandom % 60 == 0, $urandom % 3 != 0, model(s, c, op, w));
    end
    repeat (6) idle(1'b1);
    chk("rand_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_result_stage.md
MUL_RESULT_STAGE -- requirements
Module: mul_result_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 in_valid  input  1  Compressor-tree output pair valid.
REQ-005 in_ready  output  1  Stage can accept the pair this cycle.
REQ-006 in_sum  input  128  Sum vector from the 33-row compressor tree.
REQ-007 in_carry  input  128  Carry vector from the 33-row compressor tree.
REQ-008 in_op  input  2  Operation select: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
REQ-009 in_word  input  1  MULW; valid only with in_op=0.
REQ-010 flush  input  1  Synchronous kill of all in-flight entries.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  Consumer accepts result.
REQ-013 result  output  64  Final product field.

Function
REQ-014 A transfer SHALL occur on an input or output port only in a cycle where valid and ready are both high.
REQ-015 Stage A SHALL register in_sum[127:64], in_carry[127:64], op and word, plus the low sum L=in_sum[63:0]+in_carry[63:0] (64 bits) and its carry-out c64.
REQ-016 Stage B SHALL compute H=A_sum_hi+A_carry_hi+c64 modulo 2^64 and register the selected result.
REQ-017 Result selection: op=0 with word=0 gives L; op=0 with word=1 gives L[31:0] sign-extended from bit 31; op 1, 2 or 3 gives H.
REQ-018 The block SHALL not interpret signedness; the upstream Booth/tree stages encode it, and the 128-bit sum is taken modulo 2^128.
REQ-019 Latency SHALL be 2 cycles from input acceptance to out_valid when there is no backpressure, with throughput of 1 per cycle.
REQ-020 Stage B SHALL advance when it is empty or out_ready=1; Stage A SHALL advance into B when B advances or B is empty.
REQ-021 in_ready SHALL equal (A empty) OR (A advances this cycle).
REQ-022 result and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Ordering SHALL be strictly FIFO, with no reordering or dropping except on flush.
REQ-024 When flush=1, all valid bits SHALL clear next cycle, any input presented that cycle SHALL be discarded, and in_ready SHALL be 1 during flush.
REQ-025 When acceptance into A and drain of B happen in the same cycle, the pipeline SHALL shift with no bubble and no loss.
REQ-026 When word=1 with op!=0, the block SHALL treat word as 0.

Reset
REQ-027 While rst_n=0, out_valid SHALL be 0, result SHALL be 0, all stage valid bits SHALL be 0, and in_ready SHALL be 1.
REQ-028 Reset assertion mid-operation SHALL discard all entries immediately, regardless of clk.
REQ-029 The first acceptance SHALL occur on the first rising edge after reset deassertion with in_valid=1.

Configuration
REQ-030 The macro SHALL be MUL_RESULT_SKID_EN.
REQ-031 With MUL_RESULT_SKID_EN defined, a 1-entry skid buffer SHALL sit after stage B, and in_ready SHALL be driven from registers only, with no combinational path from out_ready.
REQ-032 With MUL_RESULT_SKID_EN defined, zero-backpressure latency SHALL remain 2 cycles and sustained throughput SHALL remain 1 per cycle.
REQ-033 Without MUL_RESULT_SKID_EN, no skid entry SHALL exist and in_ready MAY depend combinationally on out_ready per REQ-021.

Verification
REQ-034 Basic MUL: sum=0x5, carry=0x3, op=0, word=0 -> result=0x0000_0000_0000_0008 two cycles later.
REQ-035 Carry across bit 63: sum[63:0]=0xFFFF_FFFF_FFFF_FFFF, carry[63:0]=0x1, upper halves 0, op=1 -> result=0x0000_0000_0000_0001; the same pair with op=0 -> result=0.
REQ-036 MULW: sum=0x8000_0000, carry=0, op=0, word=1 -> result=0xFFFF_FFFF_8000_0000; sum=0x1_7FFF_FFFF, word=1 -> result=0x0000_0000_7FFF_FFFF.
REQ-037 Backpressure: hold out_ready=0 and issue 3 back-to-back ops -> in_ready drops after 2 accepted (3 with skid); on out_ready=1, results emerge in issue order on consecutive cycles.
REQ-038 Flush and reset: assert flush with 2 entries in flight -> out_valid=0 next cycle and no stale result later; pulse rst_n low mid-stream -> outputs go to 0 immediately and the next op completes normally.
